// File: rtl/amo_unit.sv
// Atomic memory operation sequencer: runs LR/SC/AMO read-modify-write
// sequences on the data bus and holds the LR/SC reservation.
module amo_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        amo_req,
  input  logic [4:0]  amo_funct5,
  input  logic        amo_dw,
  input  logic [63:0] amo_addr,
  input  logic [63:0] amo_src,
  input  logic        resv_clr,
  output logic        amo_ack,
  output logic [63:0] amo_rd,
  output logic        amo_misalign,
  output logic [63:0] d_addr,
  output logic        d_rd,
  output logic        d_wr,
  output logic [7:0]  d_be,
  output logic [63:0] d_wdata,
  input  logic [63:0] d_rdata,
  input  logic        d_ack
);

  typedef enum logic [1:0] {S_IDLE, S_RD, S_WR, S_DONE} state_e;

  typedef enum logic [4:0] {
    OP_ADD  = 5'b00000,
    OP_SWAP = 5'b00001,
    OP_LR   = 5'b00010,
    OP_SC   = 5'b00011,
    OP_XOR  = 5'b00100,
    OP_OR   = 5'b01000,
    OP_AND  = 5'b01100,
    OP_MIN  = 5'b10000,
    OP_MAX  = 5'b10100,
    OP_MINU = 5'b11000,
    OP_MAXU = 5'b11100
  } op_e;

  state_e      state_q, state_d;
  op_e         op_q, op_d;
  logic        dw_q, dw_d;
  logic        hi_q, hi_d;
  logic [63:0] src_q, src_d;
  logic [63:0] old_q, old_d;
  logic        resv_v_q, resv_v_d;
  logic [60:0] resv_addr_q, resv_addr_d;
  logic        amo_ack_q, amo_ack_d;
  logic [63:0] amo_rd_q, amo_rd_d;
  logic        amo_misalign_q, amo_misalign_d;
  logic [63:0] d_addr_q, d_addr_d;
  logic        d_rd_q, d_rd_d;
  logic        d_wr_q, d_wr_d;
  logic [7:0]  d_be_q, d_be_d;
  logic [63:0] d_wdata_q, d_wdata_d;

  op_e         req_op;
  logic        req_mis;
  logic [31:0] rsel;
  logic [63:0] rword;
  logic [63:0] newv;

  // .W operands are sign-extended to 64 bits; only the low 32 bits of the
  // result are meaningful for .W and get replicated onto the bus.
  function automatic logic [63:0] amo_alu(op_e op, logic dw, logic [63:0] a, logic [63:0] b);
    logic        lt_s;
    logic        lt_u;
    logic [63:0] r;
    lt_s = dw ? ($signed(a) < $signed(b)) : ($signed(a[31:0]) < $signed(b[31:0]));
    lt_u = dw ? (a < b) : (a[31:0] < b[31:0]);
    case (op)
      OP_SWAP: r = b;
      OP_ADD:  r = a + b;
      OP_XOR:  r = a ^ b;
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      OP_MIN:  r = lt_s ? a : b;
      OP_MAX:  r = lt_s ? b : a;
      OP_MINU: r = lt_u ? a : b;
      OP_MAXU: r = lt_u ? b : a;
      default: r = a;
    endcase
    return r;
  endfunction

  // Next-state, reservation and registered-output computation
  always_comb begin
    state_d        = state_q;
    op_d           = op_q;
    dw_d           = dw_q;
    hi_d           = hi_q;
    src_d          = src_q;
    old_d          = old_q;
    resv_v_d       = resv_v_q;
    resv_addr_d    = resv_addr_q;
    amo_ack_d      = 1'b0;
    amo_rd_d       = '0;
    amo_misalign_d = 1'b0;
    d_addr_d       = d_addr_q;
    d_rd_d         = 1'b0;
    d_wr_d         = 1'b0;
    d_be_d         = d_be_q;
    d_wdata_d      = d_wdata_q;

    req_op  = op_e'(amo_funct5);
    req_mis = amo_dw ? (amo_addr[2:0] != 3'b000) : (amo_addr[1:0] != 2'b00);
    rsel    = hi_q ? d_rdata[63:32] : d_rdata[31:0];
    rword   = dw_q ? d_rdata : {{32{rsel[31]}}, rsel};
    newv    = amo_alu(op_q, dw_q, rword, src_q);

    case (state_q)
      S_IDLE: begin
        if (amo_req) begin
          op_d     = req_op;
          dw_d     = amo_dw;
          hi_d     = amo_addr[2];
          src_d    = amo_src;
          d_addr_d = {amo_addr[63:3], 3'b000};
          d_be_d   = amo_dw ? 8'hFF : (amo_addr[2] ? 8'hF0 : 8'h0F);
          if (req_mis) begin
            state_d        = S_DONE;
            amo_ack_d      = 1'b1;
            amo_misalign_d = 1'b1;
          end else if (req_op == OP_SC) begin
            resv_v_d = 1'b0;
            if (resv_v_q && (resv_addr_q == amo_addr[63:3])) begin
              state_d   = S_WR;
              d_wr_d    = 1'b1;
              d_wdata_d = amo_dw ? amo_src : {2{amo_src[31:0]}};
            end else begin
              state_d   = S_DONE;
              amo_ack_d = 1'b1;
              amo_rd_d  = 64'd1;
            end
          end else begin
            state_d = S_RD;
            d_rd_d  = 1'b1;
          end
        end
      end
      S_RD: begin
        if (d_ack) begin
          old_d = rword;
          if (op_q == OP_LR) begin
            resv_v_d    = 1'b1;
            resv_addr_d = d_addr_q[63:3];
            state_d     = S_DONE;
            amo_ack_d   = 1'b1;
            amo_rd_d    = rword;
          end else begin
            state_d   = S_WR;
            d_wr_d    = 1'b1;
            d_wdata_d = dw_q ? newv : {2{newv[31:0]}};
          end
        end else begin
          d_rd_d = 1'b1;
        end
      end
      S_WR: begin
        if (d_ack) begin
          state_d   = S_DONE;
          amo_ack_d = 1'b1;
          amo_rd_d  = (op_q == OP_SC) ? 64'd0 : old_q;
        end else begin
          d_wr_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Applied last so an external clear overrides an LR setting the reservation
    if (resv_clr) resv_v_d = 1'b0;
  end

  // State, reservation and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= S_IDLE;
      op_q           <= OP_ADD;
      dw_q           <= 1'b0;
      hi_q           <= 1'b0;
      src_q          <= '0;
      old_q          <= '0;
      resv_v_q       <= 1'b0;
      resv_addr_q    <= '0;
      amo_ack_q      <= 1'b0;
      amo_rd_q       <= '0;
      amo_misalign_q <= 1'b0;
      d_addr_q       <= '0;
      d_rd_q         <= 1'b0;
      d_wr_q         <= 1'b0;
      d_be_q         <= '0;
      d_wdata_q      <= '0;
    end else begin
      state_q        <= state_d;
      op_q           <= op_d;
      dw_q           <= dw_d;
      hi_q           <= hi_d;
      src_q          <= src_d;
      old_q          <= old_d;
      resv_v_q       <= resv_v_d;
      resv_addr_q    <= resv_addr_d;
      amo_ack_q      <= amo_ack_d;
      amo_rd_q       <= amo_rd_d;
      amo_misalign_q <= amo_misalign_d;
      d_addr_q       <= d_addr_d;
      d_rd_q         <= d_rd_d;
      d_wr_q         <= d_wr_d;
      d_be_q         <= d_be_d;
      d_wdata_q      <= d_wdata_d;
    end
  end

  assign amo_ack      = amo_ack_q;
  assign amo_rd       = amo_rd_q;
  assign amo_misalign = amo_misalign_q;
  assign d_addr       = d_addr_q;
  assign d_rd         = d_rd_q;
  assign d_wr         = d_wr_q;
  assign d_be         = d_be_q;
  assign d_wdata      = d_wdata_q;

endmodule

// File: tb/tb_amo_unit.sv
// Directed bench for amo_unit: memory-backed bus model with configurable
// wait states, scoreboard queue of expected writeback results.
module tb_amo_unit;

  localparam logic [4:0] F_ADD  = 5'b00000;
  localparam logic [4:0] F_SWAP = 5'b00001;
  localparam logic [4:0] F_LR   = 5'b00010;
  localparam logic [4:0] F_SC   = 5'b00011;
  localparam logic [4:0] F_XOR  = 5'b00100;
  localparam logic [4:0] F_OR   = 5'b01000;
  localparam logic [4:0] F_AND  = 5'b01100;
  localparam logic [4:0] F_MAX  = 5'b10100;
  localparam logic [4:0] F_MIN  = 5'b10000;
  localparam logic [4:0] F_MINU = 5'b11000;
  localparam logic [4:0] F_MAXU = 5'b11100;

  logic        clk = 1'b0;
  logic        rst;
  logic        amo_req;
  logic [4:0]  amo_funct5;
  logic        amo_dw;
  logic [63:0] amo_addr;
  logic [63:0] amo_src;
  logic        resv_clr;
  logic        amo_ack;
  logic [63:0] amo_rd;
  logic        amo_misalign;
  logic [63:0] d_addr;
  logic        d_rd;
  logic        d_wr;
  logic [7:0]  d_be;
  logic [63:0] d_wdata;
  logic [63:0] d_rdata;
  logic        d_ack;

  logic [63:0] mem [0:511];
  int          wait_cfg = 0;
  int          wait_cnt = 0;
  int          rd_cnt = 0;
  int          wr_cnt = 0;
  logic [7:0]  last_be = '0;
  logic [63:0] last_wdata = '0;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [63:0] rd;
    logic        mis;
  } exp_t;
  exp_t sb[$];

  amo_unit dut (
    .clk(clk), .rst(rst), .amo_req(amo_req), .amo_funct5(amo_funct5),
    .amo_dw(amo_dw), .amo_addr(amo_addr), .amo_src(amo_src), .resv_clr(resv_clr),
    .amo_ack(amo_ack), .amo_rd(amo_rd), .amo_misalign(amo_misalign),
    .d_addr(d_addr), .d_rd(d_rd), .d_wr(d_wr), .d_be(d_be), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ack(d_ack)
  );

  always #5 clk = ~clk;

  // Bus slave: ack after wait_cfg stall cycles, byte-enabled writes
  assign d_ack   = (d_rd || d_wr) && (wait_cnt >= wait_cfg);
  assign d_rdata = mem[d_addr[11:3]];

  always @(posedge clk) begin
    if ((d_rd || d_wr) && !d_ack) wait_cnt <= wait_cnt + 1;
    else wait_cnt <= 0;
    if (d_rd && d_ack) rd_cnt <= rd_cnt + 1;
    if (d_wr && d_ack) begin
      wr_cnt     <= wr_cnt + 1;
      last_be    <= d_be;
      last_wdata <= d_wdata;
      for (int b = 0; b < 8; b++)
        if (d_be[b]) mem[d_addr[11:3]][8*b +: 8] = d_wdata[8*b +: 8];
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) chk("rd_wr_exclusive", {63'd0, d_rd && d_wr}, 64'd0);
  end

  // One atomic instruction: push expectation, drive request, wait for ack, compare
  task automatic do_op(input string tag, input logic [4:0] f5, input logic dw,
                       input logic [63:0] addr, input logic [63:0] src,
                       input logic [63:0] exp_rd, input logic exp_mis, input int exp_lat,
                       input int exp_rds, input int exp_wrs, input bit clr_rd);
    exp_t e;
    int   rds0, wrs0, lat;
    bit   got;
    @(posedge clk); #1;
    e.rd = exp_rd;
    e.mis = exp_mis;
    sb.push_back(e);
    rds0 = rd_cnt;
    wrs0 = wr_cnt;
    amo_req = 1'b1;
    amo_funct5 = f5;
    amo_dw = dw;
    amo_addr = addr;
    amo_src = src;
    lat = 0;
    got = 1'b0;
    while (!got && lat < 100) begin
      @(posedge clk); #1;
      lat++;
      resv_clr = clr_rd && d_rd;
      if (amo_ack) got = 1'b1;
    end
    amo_req = 1'b0;
    resv_clr = 1'b0;
    chk({tag, "_ack_seen"}, {63'd0, got}, 64'd1);
    e = sb.pop_front();
    chk({tag, "_rd"}, amo_rd, e.rd);
    chk({tag, "_misalign"}, {63'd0, amo_misalign}, {63'd0, e.mis});
    chk({tag, "_latency"}, 64'(lat), 64'(exp_lat));
    chk({tag, "_reads"}, 64'(rd_cnt - rds0), 64'(exp_rds));
    chk({tag, "_writes"}, 64'(wr_cnt - wrs0), 64'(exp_wrs));
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    bit saw_wr;
    bit any_ack;
    for (int i = 0; i < 512; i++) mem[i] = '0;
    rst = 1'b1;
    amo_req = 1'b1;
    amo_funct5 = F_ADD;
    amo_dw = 1'b1;
    amo_addr = 64'h100;
    amo_src = 64'h7;
    resv_clr = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ack", {63'd0, amo_ack}, 64'd0);
    chk("rst_misalign", {63'd0, amo_misalign}, 64'd0);
    chk("rst_amo_rd", amo_rd, 64'd0);
    chk("rst_d_addr", d_addr, 64'd0);
    chk("rst_d_rd", {63'd0, d_rd}, 64'd0);
    chk("rst_d_wr", {63'd0, d_wr}, 64'd0);
    chk("rst_d_be", {56'd0, d_be}, 64'd0);
    chk("rst_d_wdata", d_wdata, 64'd0);
    amo_req = 1'b0;
    rst = 1'b0;

    // AMOADD.D: 5 + 7
    mem[32] = 64'd5;
    do_op("add_d", F_ADD, 1'b1, 64'h100, 64'd7, 64'd5, 1'b0, 3, 1, 1, 1'b0);
    chk("add_d_mem", mem[32], 64'd12);
    chk("add_d_be", {56'd0, last_be}, 64'hFF);
    chk("add_d_wdata", last_wdata, 64'd12);

    // AMOMIN.W upper word: -2 vs 3 keeps -2
    mem[32] = 64'hFFFFFFFE_0000000C;
    do_op("min_w", F_MIN, 1'b0, 64'h104, 64'd3, 64'hFFFFFFFF_FFFFFFFE, 1'b0, 3, 1, 1, 1'b0);
    chk("min_w_be", {56'd0, last_be}, 64'hF0);
    chk("min_w_wdata_hi", {32'd0, last_wdata[63:32]}, 64'hFFFFFFFE);
    chk("min_w_mem", mem[32], 64'hFFFFFFFE_0000000C);

    // LR.D / SC.D success / SC.D fail
    mem[64] = 64'h01234567_89ABCDEF;
    do_op("lr_d", F_LR, 1'b1, 64'h200, 64'd0, 64'h01234567_89ABCDEF, 1'b0, 2, 1, 0, 1'b0);
    do_op("sc_d_ok", F_SC, 1'b1, 64'h200, 64'hCAFE, 64'd0, 1'b0, 2, 0, 1, 1'b0);
    chk("sc_d_ok_mem", mem[64], 64'hCAFE);
    do_op("sc_d_again", F_SC, 1'b1, 64'h200, 64'h1111, 64'd1, 1'b0, 1, 0, 0, 1'b0);
    chk("sc_d_again_mem", mem[64], 64'hCAFE);

    // LR.W, resv_clr pulse, SC.W fails
    mem[96] = 64'h00000000_80000001;
    do_op("lr_w", F_LR, 1'b0, 64'h300, 64'd0, 64'hFFFFFFFF_80000001, 1'b0, 2, 1, 0, 1'b0);
    @(posedge clk); #1; resv_clr = 1'b1;
    @(posedge clk); #1; resv_clr = 1'b0;
    do_op("sc_w_clr", F_SC, 1'b0, 64'h300, 64'h5, 64'd1, 1'b0, 1, 0, 0, 1'b0);

    // AMOMAXU.D all-ones vs 1
    mem[33] = '1;
    do_op("maxu_d", F_MAXU, 1'b1, 64'h108, 64'd1, 64'hFFFFFFFF_FFFFFFFF, 1'b0, 3, 1, 1, 1'b0);
    chk("maxu_d_mem", mem[33], 64'hFFFFFFFF_FFFFFFFF);

    // Misaligned AMOSWAP.D
    do_op("swap_mis", F_SWAP, 1'b1, 64'h104, 64'h99, 64'd0, 1'b1, 1, 0, 0, 1'b0);
    chk("swap_mis_mem", mem[32], 64'hFFFFFFFE_0000000C);

    // AMOADD.W wraps in 32 bits, upper word untouched
    mem[34] = 64'h12345678_FFFFFFFF;
    do_op("add_w_wrap", F_ADD, 1'b0, 64'h110, 64'd1, 64'hFFFFFFFF_FFFFFFFF, 1'b0, 3, 1, 1, 1'b0);
    chk("add_w_wrap_mem", mem[34], 64'h12345678_00000000);
    chk("add_w_wrap_be", {56'd0, last_be}, 64'h0F);

    // AMOXOR.D with two wait states on each bus phase
    wait_cfg = 2;
    mem[35] = 64'hF0F0F0F0_F0F0F0F0;
    do_op("xor_d_wait", F_XOR, 1'b1, 64'h118, 64'hFF00FF00_FF00FF00, 64'hF0F0F0F0_F0F0F0F0, 1'b0, 7, 1, 1, 1'b0);
    chk("xor_d_wait_mem", mem[35], 64'h0FF00FF0_0FF00FF0);
    wait_cfg = 0;

    // AMOAND.D
    mem[36] = 64'hFFFF0000_FFFF0000;
    do_op("and_d", F_AND, 1'b1, 64'h120, 64'h0F0F0F0F_0F0F0F0F, 64'hFFFF0000_FFFF0000, 1'b0, 3, 1, 1, 1'b0);
    chk("and_d_mem", mem[36], 64'h0F0F0000_0F0F0000);

    // AMOMAX.W lower word signed; AMOMINU.W upper word ignores src[63:32]
    mem[37] = 64'hAAAAAAAA_80000000;
    do_op("max_w", F_MAX, 1'b0, 64'h128, 64'd5, 64'hFFFFFFFF_80000000, 1'b0, 3, 1, 1, 1'b0);
    chk("max_w_mem", mem[37], 64'hAAAAAAAA_00000005);
    do_op("minu_w", F_MINU, 1'b0, 64'h12C, 64'h00000001_00000003, 64'hFFFFFFFF_AAAAAAAA, 1'b0, 3, 1, 1, 1'b0);
    chk("minu_w_mem", mem[37], 64'h00000003_00000005);
    chk("minu_w_wdata", last_wdata, 64'h00000003_00000003);

    // resv_clr coinciding with LR read ack: clear wins
    do_op("lr_clr", F_LR, 1'b1, 64'h200, 64'd0, 64'hCAFE, 1'b0, 2, 1, 0, 1'b1);
    do_op("sc_after_clr", F_SC, 1'b1, 64'h200, 64'h77, 64'd1, 1'b0, 1, 0, 0, 1'b0);

    // SC.W success on upper word: replicated data, F0 enables
    do_op("lr_w_hi", F_LR, 1'b0, 64'h304, 64'd0, 64'd0, 1'b0, 2, 1, 0, 1'b0);
    do_op("sc_w_hi", F_SC, 1'b0, 64'h304, 64'hDEADBEEF_11223344, 64'd0, 1'b0, 2, 0, 1, 1'b0);
    chk("sc_w_hi_be", {56'd0, last_be}, 64'hF0);
    chk("sc_w_hi_wdata", last_wdata, 64'h11223344_11223344);
    chk("sc_w_hi_mem", mem[96], 64'h11223344_80000001);

    // AMOOR.D with slow read, reset in first WR cycle
    do_op("lr_pre_rst", F_LR, 1'b1, 64'h200, 64'd0, 64'hCAFE, 1'b0, 2, 1, 0, 1'b0);
    wait_cfg = 4;
    mem[38] = 64'd1;
    @(posedge clk); #1;
    amo_req = 1'b1;
    amo_funct5 = F_OR;
    amo_dw = 1'b1;
    amo_addr = 64'h130;
    amo_src = 64'h10;
    saw_wr = 1'b0;
    for (int i = 0; i < 30 && !saw_wr; i++) begin
      @(posedge clk); #1;
      if (d_wr) saw_wr = 1'b1;
    end
    chk("or_rst_reached_wr", {63'd0, saw_wr}, 64'd1);
    rst = 1'b1;
    amo_req = 1'b0;
    @(posedge clk); #1;
    chk("or_rst_d_wr", {63'd0, d_wr}, 64'd0);
    chk("or_rst_d_rd", {63'd0, d_rd}, 64'd0);
    rst = 1'b0;
    wait_cfg = 0;
    any_ack = amo_ack;
    repeat (5) begin
      @(posedge clk); #1;
      any_ack = any_ack | amo_ack;
    end
    chk("or_rst_no_ack", {63'd0, any_ack}, 64'd0);
    chk("or_rst_mem", mem[38], 64'd1);
    do_op("sc_after_rst", F_SC, 1'b1, 64'h200, 64'h55, 64'd1, 1'b0, 1, 0, 0, 1'b0);
    chk("sc_after_rst_mem", mem[64], 64'hCAFE);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
